// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage. Generates the PC, issues requests
// to instruction memory, tracks the PCs of in-flight requests, buffers the
// in-order responses in a small queue and presents the head to IF/ID with
// a valid/ready handshake. Branch redirects flush the queue and discard stale
// in-flight responses through a drop counter.
// Optional build macro: IF_DELAY_SLOT_EN (MIPS-style branch delay slot).
module if_fetch_unit #(
    parameter int unsigned     PC_W     = 9,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instruction_out,
    output logic [PC_W-1:0] pc_out
);
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned CW1     = CW + 1;
    localparam logic [CW:0] DEPTH_C = CW1'(DEPTH);

    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   ost_q, ost_after;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [PC_W-1:0] ipc_q [DEPTH];
    logic [AW-1:0]   ipc_wr_q, ipc_rd_q;
    logic [31:0]     qi_q [DEPTH];
    logic [PC_W-1:0] qp_q [DEPTH];
    logic [AW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic            gnt_fire, rsp_fire, deq, enq;
    logic [PC_W-1:0] tgt_aligned;
`ifdef IF_DELAY_SLOT_EN
    logic            keep_q, keep_d;
    logic            pend_q, pend_d;
    logic [PC_W-1:0] slot_tgt_q, slot_tgt_d;
`endif

    // Request credit, handshake qualifiers and head presentation
    always_comb begin
        imem_req        = ~reset
                        & (({1'b0, ost_q} + {1'b0, occ_q}) < DEPTH_C)
                        & (drop_q == '0) & ~branch_taken;
        imem_addr       = fetch_pc_q;
        instr_valid     = (occ_q != '0) & ~branch_taken;
        instruction_out = qi_q[q_rd_q];
        pc_out          = qp_q[q_rd_q];
        gnt_fire        = imem_req & imem_gnt;
        rsp_fire        = imem_rvalid & (ost_q != '0);
        deq             = instr_valid & instr_ready;
        ost_after       = ost_q + CW'(gnt_fire) - CW'(rsp_fire);
        tgt_aligned     = branch_target & ~PC_W'(3);
    end

    // Next fetch PC, drop counter and queue pointers, with redirect override
    always_comb begin
        fetch_pc_d = gnt_fire ? fetch_pc_q + PC_W'(4) : fetch_pc_q;
        drop_d     = drop_q;
        enq        = 1'b0;
        q_rd_d     = deq ? q_rd_q + AW'(1) : q_rd_q;
`ifdef IF_DELAY_SLOT_EN
        keep_d     = keep_q;
        pend_d     = pend_q;
        slot_tgt_d = slot_tgt_q;
        // Delay-slot fetch just went out: now take the deferred redirect
        if (gnt_fire && pend_q) begin
            fetch_pc_d = slot_tgt_q;
            pend_d     = 1'b0;
        end
        if (rsp_fire) begin
            if (keep_q) begin
                enq    = 1'b1;
                keep_d = 1'b0;
            end else if (drop_q != '0) begin
                drop_d = drop_q - CW'(1);
            end else begin
                enq = 1'b1;
            end
        end
`else
        if (rsp_fire) begin
            if (drop_q != '0) drop_d = drop_q - CW'(1);
            else              enq    = 1'b1;
        end
`endif
        q_wr_d = enq ? q_wr_q + AW'(1) : q_wr_q;
        occ_d  = occ_q + CW'(enq) - CW'(deq);
        if (branch_taken) begin
            fetch_pc_d = tgt_aligned;
            drop_d     = ost_after;
`ifdef IF_DELAY_SLOT_EN
            keep_d = 1'b0;
            pend_d = 1'b0;
            if (occ_q != '0) begin
                // Head is the delay slot; everything behind it goes
                enq    = 1'b0;
                occ_d  = CW'(1);
                q_wr_d = q_rd_q + AW'(1);
            end else if (rsp_fire && (keep_q || drop_q == '0)) begin
                // Response landing this cycle is the delay slot (enq already set)
                occ_d  = CW'(1);
                q_wr_d = q_wr_q + AW'(1);
            end else if (ost_after != '0) begin
                // Keep the first response to return, drop the rest
                enq    = 1'b0;
                occ_d  = '0;
                q_wr_d = q_rd_q;
                keep_d = 1'b1;
                drop_d = ost_after - CW'(1);
            end else begin
                // Nothing fetched yet: fetch the slot at fetch_pc, redirect after
                enq        = 1'b0;
                occ_d      = '0;
                q_wr_d     = q_rd_q;
                pend_d     = 1'b1;
                slot_tgt_d = tgt_aligned;
                fetch_pc_d = fetch_pc_q;
            end
`else
            enq    = 1'b0;
            occ_d  = '0;
            q_wr_d = q_rd_q;
`endif
        end
    end

    // State registers, in-flight PC FIFO and instruction queue storage
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            ost_q      <= '0;
            drop_q     <= '0;
            occ_q      <= '0;
            ipc_wr_q   <= '0;
            ipc_rd_q   <= '0;
            q_wr_q     <= '0;
            q_rd_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ipc_q[i] <= '0;
                qi_q[i]  <= '0;
                qp_q[i]  <= '0;
            end
`ifdef IF_DELAY_SLOT_EN
            keep_q     <= 1'b0;
            pend_q     <= 1'b0;
            slot_tgt_q <= '0;
`endif
        end else begin
            fetch_pc_q <= fetch_pc_d;
            ost_q      <= ost_after;
            drop_q     <= drop_d;
            occ_q      <= occ_d;
            q_wr_q     <= q_wr_d;
            q_rd_q     <= q_rd_d;
            if (gnt_fire) begin
                ipc_q[ipc_wr_q] <= fetch_pc_q;
                ipc_wr_q        <= ipc_wr_q + AW'(1);
            end
            if (rsp_fire) ipc_rd_q <= ipc_rd_q + AW'(1);
            if (enq) begin
                qi_q[q_wr_q] <= imem_rdata;
                qp_q[q_wr_q] <= ipc_q[ipc_rd_q];
            end
`ifdef IF_DELAY_SLOT_EN
            keep_q     <= keep_d;
            pend_q     <= pend_d;
            slot_tgt_q <= slot_tgt_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench for if_fetch_unit with an in-order,
// one-cycle-latency memory model and a stream model of the expected PCs.
`timescale 1ns/1ps
module tb_if_fetch_unit;
    localparam int unsigned PC_W = 9;

    logic            clk = 1'b0;
    logic            reset;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instruction_out;
    logic [PC_W-1:0] pc_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [PC_W-1:0] pend_q[$];
    bit              mem_auto;
    bit              spurious;
    logic [PC_W-1:0] exp_pc;
    logic [PC_W-1:0] exp_fetch;
    int              grant_cnt;
    bit              wrap_armed;
    bit              ds_pending;
    logic [PC_W-1:0] ds_target;

    if_fetch_unit #(
        .PC_W    (PC_W),
        .DEPTH   (2),
        .RESET_PC(9'h000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction_out(instruction_out),
        .pc_out         (pc_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: observe handshakes/grants before the edge, then drive memory
    task automatic step();
        if (instr_valid === 1'b1 && instr_ready) begin
            check_eq("stream_pc", 32'(pc_out), 32'(exp_pc));
            check_eq("stream_data", instruction_out, mem_word(exp_pc));
            if (ds_pending) begin
                exp_pc     = ds_target;
                ds_pending = 1'b0;
            end else begin
                exp_pc = exp_pc + 9'd4;
            end
        end
        if (imem_req === 1'b1 && imem_gnt) begin
            check_eq("grant_addr", 32'(imem_addr), 32'(exp_fetch));
            pend_q.push_back(imem_addr);
            if (imem_addr == 9'h1FC) wrap_armed = 1'b1;
            exp_fetch = exp_fetch + 9'd4;
            grant_cnt++;
        end
        @(posedge clk);
        #1;
        if (reset) pend_q.delete();
        if (wrap_armed) begin
            check_eq("wrap_addr", 32'(imem_addr), 32'h0);
            wrap_armed = 1'b0;
        end
        if (mem_auto && pend_q.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_q.pop_front());
        end else begin
            imem_rvalid = spurious;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        #1;
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) break;
            step();
        end
        check_eq(tag, 32'(imem_req), 32'h1);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) break;
            step();
        end
        check_eq(tag, 32'(instr_valid), 32'h1);
    endtask

    task automatic redirect(input logic [PC_W-1:0] tgt, input logic [PC_W-1:0] aligned);
        branch_taken  = 1'b1;
        branch_target = tgt;
        exp_pc        = aligned;
        exp_fetch     = aligned;
        #1;
        check_eq("br_valid_mask", 32'(instr_valid), 32'h0);
        check_eq("br_req_mask", 32'(imem_req), 32'h0);
        step();
        branch_taken = 1'b0;
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        imem_gnt      = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = '0;
        branch_taken  = 1'b0;
        branch_target = '0;
        instr_ready   = 1'b1;
        mem_auto      = 1'b1;
        spurious      = 1'b0;
        exp_pc        = '0;
        exp_fetch     = '0;
        grant_cnt     = 0;
        wrap_armed    = 1'b0;
        ds_pending    = 1'b0;
        ds_target     = '0;

        // Reset state
        step();
        step();
        check_eq("rst_req", 32'(imem_req), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_instr", instruction_out, 32'h0);
        check_eq("rst_pc", 32'(pc_out), 32'h0);
        check_eq("rst_addr", 32'(imem_addr), 32'h0);

        // First fetch: grant now, response next cycle, valid the cycle after
        reset = 1'b0;
        #1;
        check_eq("first_req", 32'(imem_req), 32'h1);
        check_eq("first_addr", 32'(imem_addr), 32'h0);
        step();
        check_eq("lat_c1_valid", 32'(instr_valid), 32'h0);
        check_eq("lat_c1_addr", 32'(imem_addr), 32'h4);
        step();
        check_eq("lat_c2_valid", 32'(instr_valid), 32'h1);
        check_eq("lat_c2_pc", 32'(pc_out), 32'h0);
        check_eq("lat_c2_data", instruction_out, 32'hC0DE_0000);
        step();
        check_eq("lat_c3_pc", 32'(pc_out), 32'h4);
        repeat (6) step();

        // Downstream stall: credit limits issue, head held stable
        instr_ready = 1'b0;
        grant_cnt   = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i >= 2) begin
                check_eq("stall_valid", 32'(instr_valid), 32'h1);
                check_eq("stall_pc", 32'(pc_out), 32'(exp_pc));
                check_eq("stall_data", instruction_out, mem_word(exp_pc));
            end
        end
        check_eq("stall_req", 32'(imem_req), 32'h0);
        check_eq("stall_grants", 32'(grant_cnt <= 2), 32'h1);
        instr_ready = 1'b1;
        repeat (8) step();

        // Redirect with two requests outstanding
        mem_auto = 1'b0;
        repeat (4) step();
        check_eq("br_credit_full", 32'(imem_req), 32'h0);
        check_eq("br_inflight", 32'(pend_q.size()), 32'h2);
        redirect(9'h043, 9'h040);
        check_eq("br_drop_req", 32'(imem_req), 32'h0);
        mem_auto = 1'b1;
        step();
        check_eq("br_drain_req1", 32'(imem_req), 32'h0);
        step();
        check_eq("br_drain_req2", 32'(imem_req), 32'h0);
        wait_req("br_req_timeout");
        check_eq("br_target_addr", 32'(imem_addr), 32'h040);
        wait_valid("br_valid_timeout");
        check_eq("br_first_pc", 32'(pc_out), 32'h040);
        repeat (6) step();

        // PC wrap past the top of the address space
        redirect(9'h1F8, 9'h1F8);
        repeat (14) step();
        check_eq("wrap_progress", 32'(exp_pc < 9'h100), 32'h1);

        // Grant withheld: address stable; spurious response ignored
        imem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("gnt_hold_addr", 32'(imem_addr), 32'(exp_fetch));
        end
        check_eq("gnt_hold_req", 32'(imem_req), 32'h1);
        check_eq("gnt_hold_valid", 32'(instr_valid), 32'h0);
        spurious = 1'b1;
        step();
        spurious = 1'b0;
        step();
        check_eq("spur_valid", 32'(instr_valid), 32'h0);
        check_eq("spur_addr", 32'(imem_addr), 32'(exp_fetch));
        imem_gnt = 1'b1;
        repeat (8) step();

        // Reset in the middle of streaming
        reset = 1'b1;
        step();
        check_eq("mid_rst_req", 32'(imem_req), 32'h0);
        check_eq("mid_rst_valid", 32'(instr_valid), 32'h0);
        check_eq("mid_rst_instr", instruction_out, 32'h0);
        check_eq("mid_rst_pc", 32'(pc_out), 32'h0);
        check_eq("mid_rst_addr", 32'(imem_addr), 32'h0);
        exp_pc    = '0;
        exp_fetch = '0;
        reset     = 1'b0;
        #1;
        wait_valid("post_rst_timeout");
        check_eq("post_rst_pc", 32'(pc_out), 32'h0);
        repeat (6) step();

`ifdef IF_DELAY_SLOT_EN
        // Delay slot: head survives the branch, then the target follows
        instr_ready = 1'b0;
        repeat (5) step();
        ds_target  = 9'h040;
        ds_pending = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 9'h040;
        exp_fetch     = 9'h040;
        #1;
        step();
        branch_taken = 1'b0;
        instr_ready  = 1'b1;
        #1;
        check_eq("ds_head_valid", 32'(instr_valid), 32'h1);
        check_eq("ds_head_pc", 32'(pc_out), 32'(exp_pc));
        repeat (10) step();
        check_eq("ds_target_seen", 32'(ds_pending), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
